// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte-in / command-out bundle between a UART receiver front end and the
// hex command parser.
interface uart_rx_cmd_ctrl_if;
  logic [7:0] i_rx_byte;
  logic       i_rx_valid;
  logic [7:0] o_value;
  logic       o_value_valid;
  logic       o_error;
  logic [7:0] o_err_count;
  logic       o_busy;

  // Byte source side: drives received bytes, observes parser results.
  modport master (
    output i_rx_byte,
    output i_rx_valid,
    input  o_value,
    input  o_value_valid,
    input  o_error,
    input  o_err_count,
    input  o_busy
  );

  // Parser side.
  modport slave (
    input  i_rx_byte,
    input  i_rx_valid,
    output o_value,
    output o_value_valid,
    output o_error,
    output o_err_count,
    output o_busy
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses "HH<CR>" ASCII hex command frames from a UART byte stream into an
// 8-bit value. Malformed frames and intra-frame timeouts are reported as
// errors and counted (saturating).
module uart_rx_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_rx_cmd_ctrl_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      CHAR_CR  = 8'h0D;
  localparam logic [7:0]      CHAR_LF  = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GOT1    = 2'd1,
    S_GOT2    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       hi_q, hi_d;
  logic [3:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic             error_q, error_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             is_hex_c;
  logic [3:0]       nibble_c;
  logic             is_cr_c;
  logic             expire_c;

  // ASCII hex digit decode of the incoming byte.
  always_comb begin
    is_hex_c = 1'b0;
    nibble_c = 4'h0;
    if (bus.i_rx_byte >= 8'h30 && bus.i_rx_byte <= 8'h39) begin
      is_hex_c = 1'b1;
      nibble_c = 4'(bus.i_rx_byte - 8'h30);
    end else if (bus.i_rx_byte >= 8'h41 && bus.i_rx_byte <= 8'h46) begin
      is_hex_c = 1'b1;
      nibble_c = 4'(bus.i_rx_byte - 8'h37);
    end else if (bus.i_rx_byte >= 8'h61 && bus.i_rx_byte <= 8'h66) begin
      is_hex_c = 1'b1;
      nibble_c = 4'(bus.i_rx_byte - 8'h57);
    end
  end

  assign is_cr_c  = (bus.i_rx_byte == CHAR_CR);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire_c = (state_q != S_IDLE) && !bus.i_rx_valid && (cnt_q == CNT_LAST);

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    error_d       = 1'b0;
    cnt_d         = cnt_q;
    err_count_d   = err_count_q;

    if (bus.i_rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_hex_c) begin
            hi_d    = nibble_c;
            state_d = S_GOT1;
          end else if (!(is_cr_c || bus.i_rx_byte == CHAR_LF)) begin
            state_d = S_DISCARD;
            error_d = 1'b1;
          end
        end
        S_GOT1: begin
          if (is_hex_c) begin
            lo_d    = nibble_c;
            state_d = S_GOT2;
          end else if (is_cr_c) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else begin
            state_d = S_DISCARD;
            error_d = 1'b1;
          end
        end
        S_GOT2: begin
          if (is_cr_c) begin
            value_d       = {hi_q, lo_q};
            value_valid_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_DISCARD;
            error_d = 1'b1;
          end
        end
        S_DISCARD: begin
          if (is_cr_c) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire_c) begin
      state_d = S_IDLE;
      error_d = (state_q == S_GOT1) || (state_q == S_GOT2);
    end

    // Expiry returns to IDLE, so clearing there also keeps the counter from wrapping.
    if (bus.i_rx_valid || state_q == S_IDLE || expire_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (error_q && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      hi_q          <= 4'h0;
      lo_q          <= 4'h0;
      cnt_q         <= '0;
      value_q       <= 8'h00;
      value_valid_q <= 1'b0;
      error_q       <= 1'b0;
      err_count_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      error_q       <= error_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.o_value       = value_q;
  assign bus.o_value_valid = value_valid_q;
  assign bus.o_error       = error_q;
  assign bus.o_err_count   = err_count_q;
  assign bus.o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl with a cycle-stamped scoreboard of
// expected value and error pulses.
module tb_uart_rx_cmd_ctrl;

  localparam int unsigned TO = 16;
  localparam logic [7:0]  CR = 8'h0D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] val_q[$];
  int         val_at_q[$];
  int         err_at_q[$];
  int         exp_errcnt = 0;

  logic       prev_vv = 1'b0;
  logic [7:0] mon_v;
  int         mon_a;

  uart_rx_cmd_ctrl_if bus();

  uart_rx_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe for exactly one cycle (starting at a falling edge).
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_byte  = b;
    bus.i_rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      bus.i_rx_byte  = 8'h00;
    end
  endtask

  function automatic void push_val(input logic [7:0] v, input int at);
    val_q.push_back(v);
    val_at_q.push_back(at);
  endfunction

  function automatic void push_err(input int at);
    err_at_q.push_back(at);
    if (exp_errcnt < 255) exp_errcnt++;
  endfunction

  // Pulse reset for one cycle, optionally with a simultaneous byte strobe.
  task automatic reset_pulse(input logic with_byte, input logic [7:0] b);
    @(negedge clk);
    rst            = 1'b1;
    bus.i_rx_valid = with_byte;
    bus.i_rx_byte  = b;
    @(negedge clk);
    rst            = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
    exp_errcnt     = 0;
  endtask

  // Pop and compare scoreboard entries as pulses appear.
  always @(negedge clk) begin
    if (bus.o_value_valid === 1'b1) begin
      if (val_q.size() == 0) begin
        check("vv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_v = val_q.pop_front();
        mon_a = val_at_q.pop_front();
        check("value", 32'(bus.o_value), 32'(mon_v));
        check("value_cycle", 32'(cyc), 32'(mon_a));
      end
    end
    if (prev_vv) check("vv_width", 32'(bus.o_value_valid), 32'd0);
    prev_vv = (bus.o_value_valid === 1'b1);
    if (bus.o_error === 1'b1) begin
      if (err_at_q.size() == 0) begin
        check("err_unexpected", 32'd1, 32'd0);
      end else begin
        mon_a = err_at_q.pop_front();
        check("error_cycle", 32'(cyc), 32'(mon_a));
      end
    end
  end

  initial begin
    bus.i_rx_byte  = 8'h00;
    bus.i_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_value", 32'(bus.o_value), 32'h00);
    check("rst_vv", 32'(bus.o_value_valid), 32'd0);
    check("rst_error", 32'(bus.o_error), 32'd0);
    check("rst_errcnt", 32'(bus.o_err_count), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    rst = 1'b0;

    // "3F",CR with gaps between bytes
    send("3"); idle(2);
    send("F"); idle(2);
    send(CR); push_val(8'h3F, cyc + 1);
    idle(3);
    check("f1_value", 32'(bus.o_value), 32'h3F);
    check("f1_errcnt", 32'(bus.o_err_count), 32'd0);

    // "a5",CR back-to-back, then "G",CR rejected
    send("a"); send("5"); send(CR); push_val(8'hA5, cyc + 1);
    send("G"); push_err(cyc + 1);
    send(CR);
    idle(3);
    check("f2_errcnt", 32'(bus.o_err_count), 32'd1);
    check("f2_value_held", 32'(bus.o_value), 32'hA5);
    check("f2_busy", 32'(bus.o_busy), 32'd0);

    // Timeout in GOT1, then CR in GOT1
    reset_pulse(1'b0, 8'h00);
    check("r1_value", 32'(bus.o_value), 32'h00);
    send("1"); push_err(cyc + 1 + TO);
    idle(1);
    check("to_busy_high", 32'(bus.o_busy), 32'd1);
    idle(TO + 1);
    check("to_busy_low", 32'(bus.o_busy), 32'd0);
    check("to_errcnt", 32'(bus.o_err_count), 32'd1);
    send("7"); send(CR); push_err(cyc + 1);
    idle(3);
    check("to_cr_errcnt", 32'(bus.o_err_count), 32'd2);

    // Partial frame dropped by reset; reset also swallows a simultaneous strobe
    send("4");
    reset_pulse(1'b1, "X");
    check("r2_busy", 32'(bus.o_busy), 32'd0);
    check("r2_errcnt", 32'(bus.o_err_count), 32'd0);
    send("5"); send("6"); send(CR); push_val(8'h56, cyc + 1);
    idle(3);
    check("r2_value", 32'(bus.o_value), 32'h56);
    check("r2_errcnt_after", 32'(bus.o_err_count), 32'd0);

    // CR arriving on the exact expiry cycle in GOT2 is accepted
    send("9"); send("C");
    idle(TO - 1);
    send(CR); push_val(8'h9C, cyc + 1);
    idle(3);
    check("edge_value", 32'(bus.o_value), 32'h9C);
    check("edge_errcnt", 32'(bus.o_err_count), 32'd0);

    // One cycle later the same frame times out in GOT2
    send("9"); send("D"); push_err(cyc + 1 + TO);
    idle(TO + 2);
    check("to2_errcnt", 32'(bus.o_err_count), 32'd1);
    check("to2_value_held", 32'(bus.o_value), 32'h9C);
    check("to2_busy", 32'(bus.o_busy), 32'd0);

    // Timeout in DISCARD returns to IDLE without an error
    send("Q"); push_err(cyc + 1);
    idle(TO + 3);
    check("to3_errcnt", 32'(bus.o_err_count), 32'd2);
    check("to3_busy", 32'(bus.o_busy), 32'd0);

    // Saturation of the error counter
    repeat (300) begin
      send("Z"); push_err(cyc + 1);
      send(CR);
    end
    idle(3);
    check("sat_errcnt", 32'(bus.o_err_count), 32'(exp_errcnt));
    check("sat_errcnt_255", 32'(bus.o_err_count), 32'd255);
    send("0"); send("0"); send(CR); push_val(8'h00, cyc + 1);
    idle(3);
    check("sat_value", 32'(bus.o_value), 32'h00);
    check("sat_errcnt_after", 32'(bus.o_err_count), 32'd255);

    check("val_q_drained", 32'(val_q.size()), 32'd0);
    check("err_q_drained", 32'(err_at_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 25000000, meaning intra-frame inter-byte timeout in clocks (1 s at 25 MHz); legal range is 2 or more.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_rx_byte, input, 8 bits: received byte from the UART receiver, sampled only when i_rx_valid=1.
REQ-005 The block SHALL have port i_rx_valid, input, 1 bit: single-cycle byte strobe from the UART receiver.
REQ-006 The block SHALL have port o_value, output, 8 bits: last successfully parsed command value.
REQ-007 The block SHALL have port o_value_valid, output, 1 bit: one-cycle pulse when o_value updates.
REQ-008 The block SHALL have port o_error, output, 1 bit: one-cycle pulse per rejected frame.
REQ-009 The block SHALL have port o_err_count, output, 8 bits: saturating count of rejected frames.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high when the parser state is not IDLE.

Function
REQ-011 Frame format SHALL be two ASCII hex digits (0-9, A-F, a-f; high nibble first) then CR (0x0D), giving value {hi,lo}.
REQ-012 The state machine SHALL have exactly four states: IDLE, GOT1, GOT2 and DISCARD; transitions occur only on cycles with i_rx_valid=1, except timeout.
REQ-013 In IDLE: a hex byte stores the high nibble and moves to GOT1; CR or LF (0x0A) stays in IDLE with no error; any other byte moves to DISCARD and pulses o_error.
REQ-014 In GOT1: a hex byte stores the low nibble and moves to GOT2; CR moves to IDLE and pulses o_error; any other byte moves to DISCARD and pulses o_error.
REQ-015 In GOT2: CR loads o_value={hi,lo}, pulses o_value_valid and moves to IDLE; any other byte, including hex and LF, moves to DISCARD and pulses o_error.
REQ-016 In DISCARD: CR moves to IDLE with no additional error; all other bytes stay in DISCARD.
REQ-017 o_value, o_value_valid and o_error SHALL be registered and assert on the cycle after the i_rx_valid cycle that caused them; pulses SHALL be exactly 1 cycle wide.
REQ-018 o_value SHALL hold its value between updates, and a rejected frame SHALL never alter it.
REQ-019 The timeout counter SHALL clear on every i_rx_valid cycle and on every cycle in IDLE, and SHALL increment on every other cycle in GOT1, GOT2 or DISCARD.
REQ-020 When the timeout counter equals TIMEOUT_CYCLES-1 with i_rx_valid=0, the state SHALL go to IDLE; o_error SHALL pulse only if the state was GOT1 or GOT2, not DISCARD.
REQ-021 If timeout expiry and i_rx_valid coincide on the same cycle, the byte SHALL be processed and the timeout ignored.
REQ-022 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES), and the counter SHALL never wrap.
REQ-023 o_err_count SHALL increment by 1 on each cycle in which o_error is set, and SHALL saturate at 255.
REQ-024 o_busy SHALL be decoded from the registered state: 1 in GOT1, GOT2 and DISCARD, 0 in IDLE.
REQ-025 Back-to-back i_rx_valid strobes on consecutive cycles SHALL each be processed with no byte lost.

Reset
REQ-026 While i_rst=1 at a clock edge, the state SHALL become IDLE, the nibble registers and timeout counter SHALL become 0, and the outputs SHALL be o_value=0x00, o_value_valid=0, o_error=0, o_err_count=0 and o_busy=0.
REQ-027 Reset SHALL override any simultaneous i_rx_valid; a partial frame interrupted by reset SHALL be dropped with no error counted.

Verification (bench uses TIMEOUT_CYCLES=16)
REQ-028 Bytes "3F",CR -> o_value=0x3F and o_value_valid high exactly 1 cycle, 1 cycle after the CR strobe; o_err_count=0.
REQ-029 Bytes "a5",CR sent back-to-back on consecutive cycles -> o_value=0xA5; then "G",CR -> one o_error pulse, o_err_count=1, o_value stays 0xA5.
REQ-030 "1" then 16 idle cycles -> o_error pulses once and o_busy falls; a following "7",CR -> error (CR in GOT1), o_err_count=2.
REQ-031 "4", reset for 1 cycle, then "56",CR -> o_value=0x56, o_err_count=0.
REQ-032 A CR strobe on the exact cycle the timeout would expire in GOT2 -> valid frame accepted, no error.
REQ-033 300 frames of "Z",CR -> o_err_count stops at 255; a subsequent "00",CR yields o_value=0x00 with o_value_valid pulsing.
